// File: rtl/seven_segment_scan_if.sv
// Bundle between a display controller and the seven-segment scanner.
// Glyph/control request signals flow master->slave, drive signals flow back.
// Optional blink mask exists only when SEVEN_SEGMENT_BLINK_EN is defined.
interface seven_segment_scan_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] nums;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic [3:0]              brightness;
`ifdef SEVEN_SEGMENT_BLINK_EN
   logic [NUM_DIGITS-1:0]   blink_mask;
`endif
   logic [6:0]              display;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   digit;
   logic                    frame_tick;

`ifdef SEVEN_SEGMENT_BLINK_EN
   modport master (output nums, dp_in, blank_in, brightness, blink_mask,
                   input  display, dp, digit, frame_tick);
   modport slave  (input  nums, dp_in, blank_in, brightness, blink_mask,
                   output display, dp, digit, frame_tick);
`else
   modport master (output nums, dp_in, blank_in, brightness,
                   input  display, dp, digit, frame_tick);
   modport slave  (input  nums, dp_in, blank_in, brightness,
                   output display, dp, digit, frame_tick);
`endif
endinterface

// File: rtl/seven_segment_scan.sv
// Multiplexed active-low seven-segment scanner with frame snapshot, PWM dimming and anti-ghost guard.
// Latency: 1 cycle, every output is registered from the current slot counter, digit index and snapshot.
// No backpressure: free-running scan; optional blinking enabled by macro SEVEN_SEGMENT_BLINK_EN.
module seven_segment_scan #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 65536
`ifdef SEVEN_SEGMENT_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 32
`endif
) (
   input logic                 clk,
   input logic                 rst,
   seven_segment_scan_if.slave scan_if
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]           cnt_q;
   logic [IW-1:0]           idx_q;
   logic [4*NUM_DIGITS-1:0] snap_nums_q;
   logic [NUM_DIGITS-1:0]   snap_dp_q;
   logic [NUM_DIGITS-1:0]   snap_blank_q;
   logic [6:0]              display_q, display_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   digit_q, digit_d;
   logic                    frame_tick_q, frame_tick_d;
   logic                    frame_end;
   logic                    blank_eff;
   logic [3:0]              hex_code;
   logic [6:0]              glyph;
   logic [3:0]              phase;

   // Last cycle of the last slot: the snapshot and next frame start here.
   assign frame_end = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);
   assign phase     = cnt_q[CW-1 -: 4];
   assign hex_code  = snap_nums_q[{idx_q, 2'b00} +: 4];

`ifdef SEVEN_SEGMENT_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [FW-1:0]         fcnt_q;
   logic                  blink_off_q;
   logic [NUM_DIGITS-1:0] snap_blink_q;

   // Frame counter; the blink phase flips every BLINK_FRAMES frames, aligned to frame starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         fcnt_q       <= '0;
         blink_off_q  <= 1'b0;
         snap_blink_q <= scan_if.blink_mask;
      end else if (frame_end) begin
         snap_blink_q <= scan_if.blink_mask;
         if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
            fcnt_q      <= '0;
            blink_off_q <= ~blink_off_q;
         end else begin
            fcnt_q <= fcnt_q + FW'(1);
         end
      end
   end

   assign blank_eff = snap_blank_q[idx_q] | (blink_off_q & snap_blink_q[idx_q]);
`else
   assign blank_eff = snap_blank_q[idx_q];
`endif

   // Hex to active-low {g,f,e,d,c,b,a} glyph.
   always_comb begin
      glyph = 7'b1111111;
      case (hex_code)
         4'h0: glyph = 7'b1000000;
         4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;
         4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;
         4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;
         4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b1000110;
         4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;
         4'hF: glyph = 7'b0001110;
         default: glyph = 7'b1111111;
      endcase
   end

   // Next output values: slot cycle 0 is the anti-ghost guard, PWM gates the rest, blank keeps strobe.
   always_comb begin
      digit_d      = '1;
      display_d    = 7'b1111111;
      dp_d         = 1'b1;
      frame_tick_d = (cnt_q == '0) && (idx_q == '0);
      if ((cnt_q != '0) && (phase <= scan_if.brightness)) begin
         digit_d = ~(NUM_DIGITS'(1) << idx_q);
         if (!blank_eff) begin
            display_d = glyph;
            dp_d      = ~snap_dp_q[idx_q];
         end
      end
   end

   // Slot counter and digit index; the counter wraps naturally as REFRESH_DIV is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
         if (cnt_q == CNT_MAX) begin
            idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
         end
      end
   end

   // Input snapshot: follows inputs during reset, otherwise refreshed only at frame end.
   always_ff @(posedge clk) begin
      if (rst || frame_end) begin
         snap_nums_q  <= scan_if.nums;
         snap_dp_q    <= scan_if.dp_in;
         snap_blank_q <= scan_if.blank_in;
      end
   end

   // Registered outputs; reset forces everything off.
   always_ff @(posedge clk) begin
      if (rst) begin
         digit_q      <= '1;
         display_q    <= 7'b1111111;
         dp_q         <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         digit_q      <= digit_d;
         display_q    <= display_d;
         dp_q         <= dp_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign scan_if.digit      = digit_q;
   assign scan_if.display    = display_q;
   assign scan_if.dp         = dp_q;
   assign scan_if.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench for seven_segment_scan with NUM_DIGITS=4, REFRESH_DIV=16.
// Walks whole frames and checks every output cycle against hand-derived glyph tables.
// Covers reset, scan order, snapshot timing, PWM, blank/dp and mid-slot reset.
module tb_seven_segment_scan;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   seven_segment_scan_if #(.NUM_DIGITS(4)) sif ();

   seven_segment_scan #(.NUM_DIGITS(4), .REFRESH_DIV(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .scan_if (sif)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001;
   localparam logic [6:0] GA = 7'b0001000;
   localparam logic [6:0] GB = 7'b0000011;
   localparam logic [6:0] GC = 7'b1000110;
   localparam logic [6:0] GD = 7'b0100001;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_off(input string tag);
      chk({tag, "_digit"}, 32'(sif.digit), 32'hF);
      chk({tag, "_display"}, 32'(sif.display), 32'h7F);
      chk({tag, "_dp"}, 32'(sif.dp), 32'h1);
      chk({tag, "_tick"}, 32'(sif.frame_tick), 32'h0);
   endtask

   // Checks output cycles 0..last_k of one frame; optionally updates inputs after cycle chg_at.
   task automatic run_frame(input logic [6:0] g0, input logic [6:0] g1,
                            input logic [6:0] g2, input logic [6:0] g3,
                            input logic [3:0] dpm, input logic [3:0] blm,
                            input logic [3:0] br, input int last_k, input int chg_at,
                            input logic [15:0] n_nums, input logic [3:0] n_dp,
                            input logic [3:0] n_bl);
      logic [6:0] gl [4];
      logic [3:0] one;
      logic [3:0] exp_dig;
      logic [6:0] exp_disp;
      logic       exp_dp;
      logic       on;
      int         slot;
      int         c;
      gl[0] = g0; gl[1] = g1; gl[2] = g2; gl[3] = g3;
      one = 4'b0001;
      sif.brightness = br;
      for (int k = 0; k <= last_k; k++) begin
         tick();
         slot = k / 16;
         c    = k % 16;
         on   = (c != 0) && (c <= int'(br));
         exp_dig  = on ? ~(one << slot) : 4'hF;
         exp_disp = (on && !blm[slot]) ? gl[slot] : 7'h7F;
         exp_dp   = (on && !blm[slot]) ? ~dpm[slot] : 1'b1;
         chk($sformatf("digit_k%0d", k), 32'(sif.digit), 32'(exp_dig));
         chk($sformatf("display_k%0d", k), 32'(sif.display), 32'(exp_disp));
         chk($sformatf("dp_k%0d", k), 32'(sif.dp), 32'(exp_dp));
         chk($sformatf("tick_k%0d", k), 32'(sif.frame_tick), (k == 0) ? 32'h1 : 32'h0);
         if (k == chg_at) begin
            sif.nums     = n_nums;
            sif.dp_in    = n_dp;
            sif.blank_in = n_bl;
         end
      end
   endtask

   initial begin
      sif.nums       = 16'h4321;
      sif.dp_in      = 4'b0000;
      sif.blank_in   = 4'b0000;
      sif.brightness = 4'd15;
`ifdef SEVEN_SEGMENT_BLINK_EN
      sif.blink_mask = 4'b0000;
`endif
      // Reset held: all outputs off.
      tick();
      tick();
      tick();
      chk_off("reset");

      // First frame after release: 1,2,3,4 at full brightness.
      rst = 1'b0;
      run_frame(G1, G2, G3, G4, 4'b0000, 4'b0000, 4'd15, 63, -1, 16'h4321, 4'b0000, 4'b0000);

      // nums changes in the middle of digit 2's slot; this frame must keep the old glyphs.
      run_frame(G1, G2, G3, G4, 4'b0000, 4'b0000, 4'd15, 63, 40, 16'hABCD, 4'b0000, 4'b0000);

      // Next frame shows the new snapshot: D,C,B,A.
      run_frame(GD, GC, GB, GA, 4'b0000, 4'b0000, 4'd15, 63, -1, 16'hABCD, 4'b0000, 4'b0000);

      // brightness=3: only phases 1..3 light; blank/dp changes are staged for the next frame.
      run_frame(GD, GC, GB, GA, 4'b0000, 4'b0000, 4'd3, 63, 50, 16'hABCD, 4'b0001, 4'b0010);

      // Digit 1 blanked but strobing, digit 0 dp lit; stop at cnt=8 of digit 2.
      run_frame(GD, GC, GB, GA, 4'b0001, 4'b0010, 4'd15, 40, -1, 16'hABCD, 4'b0001, 4'b0010);

      // One-cycle reset at cnt=9 of digit 2: outputs off next cycle, then scan restarts at digit 0.
      rst = 1'b1;
      tick();
      chk_off("midreset");
      rst = 1'b0;
      run_frame(GD, GC, GB, GA, 4'b0001, 4'b0010, 4'd15, 63, -1, 16'hABCD, 4'b0001, 4'b0010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seven_segment_scan.md
SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 65536: clock cycles per digit slot; power of two, >=16.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 nums  input  4*NUM_DIGITS  hex code per digit; digit i = nums[4i+3:4i].
REQ-006 dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-007 blank_in  input  NUM_DIGITS  per-digit blank, 1 = segments and dp off for that digit.
REQ-008 brightness  input  4  PWM duty level, 0 = 1/16 duty, 15 = full duty.
REQ-009 display  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal point drive, active-low.
REQ-011 digit  output  NUM_DIGITS  digit anode enable, active-low, at most one bit low.
REQ-012 frame_tick  output  1  one-cycle pulse when digit 0 begins a new frame.

Function
REQ-013 Internal slot counter cnt counts 0..REFRESH_DIV-1 and wraps; digit index idx advances 0,1,..,NUM_DIGITS-1,0 on each cnt wrap.
REQ-014 Scan order starts at digit 0 (nums[3:0]); digit[idx] low during its slot.
REQ-015 nums, dp_in and blank_in are captured into a snapshot on the edge where cnt=REFRESH_DIV-1 and idx=NUM_DIGITS-1; displayed glyphs come only from the snapshot (no mid-frame tearing).
REQ-016 Glyph map: 0-9 as standard active-low codes (0=1000000, 1=1111001, 8=0000000), A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 PWM: phase = cnt[log2(REFRESH_DIV)-1 -: 4]; digit enabled only while phase <= brightness; otherwise digit all-ones, display=1111111, dp=1.
REQ-018 brightness is sampled combinationally each cycle; change takes effect from the next edge.
REQ-019 Blanked digit: digit bit still strobes low (timing preserved), display=1111111, dp=1.
REQ-020 All outputs registered; output in cycle n+1 reflects cnt/idx/snapshot of cycle n (latency 1).
REQ-021 Anti-ghosting: in the first output cycle of every slot, digit is all-ones and display/dp are off.
REQ-022 frame_tick asserted for exactly one cycle, concurrent with the first output cycle of digit 0's slot.
REQ-023 NUM_DIGITS=1: idx stays 0, snapshot taken every slot, frame_tick once per slot.

Reset
REQ-024 While rst high: cnt=0, idx=0, digit all-ones, display=1111111, dp=1, frame_tick=0, snapshot loads current inputs each cycle.
REQ-025 Reset asserted mid-slot aborts immediately at next edge; first cycle after release restarts at cnt=0, idx=0.

Configuration
REQ-026 Macro SEVEN_SEGMENT_BLINK_EN defined: adds input blink_mask (NUM_DIGITS) and parameter BLINK_FRAMES (default 32); a frame counter toggles a blink phase every BLINK_FRAMES frames; digits with mask bit set are blanked per REQ-019 during the off phase; blink_mask is captured in the snapshot.
REQ-027 Macro undefined: no blink_mask port, no frame counter, no BLINK_FRAMES parameter; behaviour per REQ-013..REQ-025 only.

Verification (REFRESH_DIV=16, NUM_DIGITS=4)
REQ-028 Release rst, nums=16'h4321, brightness=15 -> digit sequence 1110,1101,1011,0111 each 16 cycles, display codes of 1,2,3,4, frame_tick every 64 cycles.
REQ-029 Change nums 4321->ABCD in middle of digit 2 slot -> current frame still shows 3,4; next frame shows D,C,B,A.
REQ-030 brightness=3 -> each digit low only for output cycles mapped to phases 1..3 within the slot (phase 0 lost to guard), off for remaining 12.
REQ-031 blank_in=4'b0010, dp_in=4'b0001 -> digit 1 strobes with display=1111111; digit 0 shows dp=0; others dp=1.
REQ-032 Assert rst for one cycle at cnt=9 of digit 2 -> outputs off next cycle, scan restarts at digit 0, cnt=0.
REQ-033 With SEVEN_SEGMENT_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b1000 -> digit 3 shows glyph 2 frames, blank 2 frames, repeating; other digits unaffected.
